// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU and load-return paths onto the single
// register-file write port, oldest entry first. Optional macro: WB_ZERO_REG_DROP_EN.
module wb_arbiter #(
  parameter int unsigned data_width   = 32,
  parameter int unsigned select_width = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [select_width-1:0]      alu_addr,
  input  logic [data_width-1:0]        alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [select_width-1:0]      mem_addr,
  input  logic [data_width-1:0]        mem_data,
  output logic                         RegWrite,
  output logic [select_width-1:0]      write_address,
  output logic [data_width-1:0]        write_data,
  output logic [(2**select_width)-1:0] pending_mask,
  output logic                         idle
);

  logic                    alu_hold_valid;
  logic [select_width-1:0] alu_hold_addr;
  logic [data_width-1:0]   alu_hold_data;
  logic                    mem_hold_valid;
  logic [select_width-1:0] mem_hold_addr;
  logic [data_width-1:0]   mem_hold_data;
  logic                    mem_older;

  logic alu_grant_c, mem_grant_c;
  logic alu_acc_c, mem_acc_c;
  logic alu_load_c, mem_load_c;
  logic alu_stays_c, mem_stays_c;
  logic mem_older_next_c;

  // Grant is a function of registered state only, so ready never depends on valid.
  assign alu_grant_c = alu_hold_valid & (!mem_hold_valid | !mem_older);
  assign mem_grant_c = mem_hold_valid & (!alu_hold_valid | mem_older);

  assign alu_ready = !alu_hold_valid | alu_grant_c;
  assign mem_ready = !mem_hold_valid | mem_grant_c;

  assign alu_acc_c = alu_valid & alu_ready;
  assign mem_acc_c = mem_valid & mem_ready;

`ifdef WB_ZERO_REG_DROP_EN
  assign alu_load_c = alu_acc_c & (alu_addr != '0);
  assign mem_load_c = mem_acc_c & (mem_addr != '0);
`else
  assign alu_load_c = alu_acc_c;
  assign mem_load_c = mem_acc_c;
`endif

  assign alu_stays_c = alu_hold_valid & !alu_grant_c;
  assign mem_stays_c = mem_hold_valid & !mem_grant_c;

  // Age bit tracks which hold holds the older entry; simultaneous loads favour mem.
  always_comb begin
    mem_older_next_c = mem_older;
    if (mem_load_c) begin
      mem_older_next_c = !alu_stays_c;
    end else if (alu_load_c) begin
      mem_older_next_c = mem_stays_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_hold_valid <= 1'b0;
      alu_hold_addr  <= '0;
      alu_hold_data  <= '0;
      mem_hold_valid <= 1'b0;
      mem_hold_addr  <= '0;
      mem_hold_data  <= '0;
      mem_older      <= 1'b0;
    end else begin
      alu_hold_valid <= alu_load_c | alu_stays_c;
      mem_hold_valid <= mem_load_c | mem_stays_c;
      mem_older      <= mem_older_next_c;
      if (alu_load_c) begin
        alu_hold_addr <= alu_addr;
        alu_hold_data <= alu_data;
      end
      if (mem_load_c) begin
        mem_hold_addr <= mem_addr;
        mem_hold_data <= mem_data;
      end
    end
  end

  // Output register; address and data keep their last values when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite      <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      RegWrite <= alu_grant_c | mem_grant_c;
      if (mem_grant_c) begin
        write_address <= mem_hold_addr;
        write_data    <= mem_hold_data;
      end else if (alu_grant_c) begin
        write_address <= alu_hold_addr;
        write_data    <= alu_hold_data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (alu_hold_valid) pending_mask[alu_hold_addr] = 1'b1;
    if (mem_hold_valid) pending_mask[mem_hold_addr] = 1'b1;
    if (RegWrite)       pending_mask[write_address] = 1'b1;
  end

  assign idle = !alu_hold_valid & !mem_hold_valid & !RegWrite;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against an age-stamped entry model.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        RegWrite;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic        idle;

  wb_arbiter #(.data_width(32), .select_width(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .RegWrite(RegWrite), .write_address(write_address), .write_data(write_data),
    .pending_mask(pending_mask), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each source holds at most one entry stamped with its arrival order.
  bit          m_hv [2];
  logic [4:0]  m_ha [2];
  logic [31:0] m_hd [2];
  int          m_hs [2];
  int          m_seq;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] rf_obs [32];

`ifdef WB_ZERO_REG_DROP_EN
  localparam bit drop_zero = 1'b1;
`else
  localparam bit drop_zero = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hv[i] = 0; m_ha[i] = '0; m_hd[i] = '0; m_hs[i] = 0;
    end
    m_seq = 0; m_we = 0; m_wa = '0; m_wd = '0;
  endtask

  function automatic int model_grant();
    if (m_hv[0] && m_hv[1]) return (m_hs[1] < m_hs[0]) ? 1 : 0;
    if (m_hv[0]) return 0;
    if (m_hv[1]) return 1;
    return -1;
  endfunction

  task automatic check_model();
    int g;
    logic [31:0] mask;
    g = model_grant();
    mask = '0;
    for (int i = 0; i < 2; i++) if (m_hv[i]) mask = mask | (32'd1 << m_ha[i]);
    if (m_we) mask = mask | (32'd1 << m_wa);
    check_eq("alu_ready", 64'(alu_ready), 64'(!m_hv[0] || g == 0));
    check_eq("mem_ready", 64'(mem_ready), 64'(!m_hv[1] || g == 1));
    check_eq("RegWrite", 64'(RegWrite), 64'(m_we));
    check_eq("write_address", 64'(write_address), 64'(m_wa));
    check_eq("write_data", 64'(write_data), 64'(m_wd));
    check_eq("pending_mask", 64'(pending_mask), 64'(mask));
    check_eq("idle", 64'(idle), 64'(!m_hv[0] && !m_hv[1] && !m_we));
    if (RegWrite) rf_obs[write_address] = write_data;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    int g;
    bit rdy_a, rdy_m;
    g = model_grant();
    rdy_a = !m_hv[0] || g == 0;
    rdy_m = !m_hv[1] || g == 1;
    if (g >= 0) begin
      m_we = 1; m_wa = m_ha[g]; m_wd = m_hd[g]; m_hv[g] = 0;
    end else begin
      m_we = 0;
    end
    if (mem_valid && rdy_m && !(drop_zero && mem_addr == 5'd0)) begin
      m_hv[1] = 1; m_ha[1] = mem_addr; m_hd[1] = mem_data; m_hs[1] = m_seq; m_seq++;
    end
    if (alu_valid && rdy_a && !(drop_zero && alu_addr == 5'd0)) begin
      m_hv[0] = 1; m_ha[0] = alu_addr; m_hd[0] = alu_data; m_hs[0] = m_seq; m_seq++;
    end
  endtask

  task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md);
    @(negedge clk);
    check_model();
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    model_edge();
    @(posedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    mem_valid = 0; mem_addr = '0; mem_data = '0;
    for (int i = 0; i < 32; i++) rf_obs[i] = '0;
    model_reset();
    #12;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write
    cycle(1, 5'd3, 32'h0000_00AA, 0, 5'd0, 32'd0);
    drain(4);
    check_eq("rf3", 64'(rf_obs[3]), 64'h0000_00AA);

    // Simultaneous acceptance, same address, ALU valid held
    cycle(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
    cycle(1, 5'd5, 32'h11, 0, 5'd0, 32'd0);
    drain(4);
    check_eq("rf5", 64'(rf_obs[5]), 64'h11);

    // Age order under contention
    cycle(1, 5'd9, 32'h99, 0, 5'd0, 32'd0);
    cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'h33);
    cycle(1, 5'd7, 32'h44, 0, 5'd0, 32'd0);
    drain(4);
    check_eq("rf7", 64'(rf_obs[7]), 64'h44);

    // Streaming from both sources
    for (int i = 0; i < 20; i++)
      cycle(1, 5'(1 + i % 15), 32'(32'h1000 + i), 1, 5'(16 + i % 15), 32'(32'h2000 + i));
    drain(4);

    // Address zero
    cycle(1, 5'd0, 32'h0000_DEAD, 0, 5'd0, 32'd0);
    drain(4);
    check_eq("rf0", 64'(rf_obs[0]), drop_zero ? 64'h0 : 64'h0000_DEAD);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, 5'($urandom), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom), $urandom);
    drain(4);

    // Reset mid-stream with both holds full
    cycle(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    cycle(1, 5'd14, 32'hC1, 1, 5'd15, 32'hD1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    alu_valid = 0; mem_valid = 0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    check_model();
    rst_n = 1'b1;
    drain(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
